// File: rtl/banco_pkg.sv
// Shared constants and write-source encoding for the MIPS register file.
package banco_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 6;
    localparam int unsigned ADDR_ZERO    = 0;
    localparam int unsigned ADDR_RA_DEF  = 1;
    localparam int unsigned ADDR_RP_DEF  = 3;
    localparam int unsigned RP_BASE_DEF  = 224;
    localparam int unsigned RP_LIMIT_DEF = 128;

    // Which port, if any, updates a given register on the next edge
    typedef enum logic [1:0] {
        FonteNenhuma,
        FonteGeral,
        FonteLink,
        FontePilha
    } fonte_escrita_e;

    // Per-register arbitration: $rp prefers PilhaE, $ra prefers JAL, the rest take RegWrite.
    // A rejected PilhaE still owns $rp, so it blocks a general write to it.
    function automatic fonte_escrita_e resolve_fonte(
        input logic eh_zero,
        input logic eh_ra,
        input logic eh_rp,
        input logic geral_alvo,
        input logic pilha_e,
        input logic rp_aceito,
        input logic jal
    );
        if (eh_zero) return FonteNenhuma;
        if (eh_rp && pilha_e) return rp_aceito ? FontePilha : FonteNenhuma;
        if (eh_ra && jal) return FonteLink;
        if (geral_alvo) return FonteGeral;
        return FonteNenhuma;
    endfunction

endpackage

// File: rtl/pilha_guarda.sv
// Stack-pointer bounds check with sticky overflow/underflow flags.
module pilha_guarda #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RP_BASE  = 224,
    parameter int unsigned RP_LIMIT = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pilha_e,
    input  logic [DATA_W-1:0] rp,
    input  logic              limpa_flags,
    output logic              rp_aceito,
    output logic              pilha_overflow,
    output logic              pilha_underflow
);

    logic abaixo;
    logic acima;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Bound comparison and sticky-flag next state; a new violation beats a clear
    always_comb begin
        abaixo      = rp < DATA_W'(RP_LIMIT);
        acima       = rp > DATA_W'(RP_BASE);
        rp_aceito   = pilha_e && !abaixo && !acima;
        overflow_d  = limpa_flags ? 1'b0 : overflow_q;
        underflow_d = limpa_flags ? 1'b0 : underflow_q;
        if (pilha_e && abaixo) overflow_d = 1'b1;
        if (pilha_e && acima) underflow_d = 1'b1;
    end

    // Flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign pilha_overflow  = overflow_q;
    assign pilha_underflow = underflow_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised MIPS register file: two async read ports, general/$ra/$rp write ports,
// stack-bound checking. Define REG_BYPASS_EN to forward same-cycle write data to reads.
module banco_registradores_param
    import banco_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ADDR_RA  = ADDR_RA_DEF,
    parameter int unsigned ADDR_RP  = ADDR_RP_DEF,
    parameter int unsigned RP_BASE  = RP_BASE_DEF,
    parameter int unsigned RP_LIMIT = RP_LIMIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_rs,
    input  logic [ADDR_W-1:0] addr_rt,
    input  logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] escrita_dado,
    input  logic [DATA_W-1:0] link_dado,
    input  logic [DATA_W-1:0] rp,
    input  logic              RegWrite,
    input  logic              PilhaE,
    input  logic              JAL,
    input  logic              limpa_flags,
    output logic [DATA_W-1:0] dado1,
    output logic [DATA_W-1:0] dado2,
    output logic              pilha_overflow,
    output logic              pilha_underflow
);

    localparam int unsigned REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q       [REGS];
    logic [DATA_W-1:0] dado_escrita [REGS];
    fonte_escrita_e    fonte        [REGS];
    logic              rp_aceito;
    logic [ADDR_W-1:0] endereco2;

    pilha_guarda #(
        .DATA_W   (DATA_W),
        .RP_BASE  (RP_BASE),
        .RP_LIMIT (RP_LIMIT)
    ) u_pilha_guarda (
        .clock           (clock),
        .reset           (reset),
        .pilha_e         (PilhaE),
        .rp              (rp),
        .limpa_flags     (limpa_flags),
        .rp_aceito       (rp_aceito),
        .pilha_overflow  (pilha_overflow),
        .pilha_underflow (pilha_underflow)
    );

    // Arbitrate writers per register; unwritten registers hold their value
    always_comb begin
        for (int unsigned i = 0; i < REGS; i++) begin
            fonte[i] = resolve_fonte(
                i == ADDR_ZERO,
                i == ADDR_RA,
                i == ADDR_RP,
                RegWrite && (addr_rd == ADDR_W'(i)),
                PilhaE,
                rp_aceito,
                JAL
            );
            unique case (fonte[i])
                FontePilha: dado_escrita[i] = rp;
                FonteLink:  dado_escrita[i] = link_dado;
                FonteGeral: dado_escrita[i] = escrita_dado;
                default:    dado_escrita[i] = regs_q[i];
            endcase
        end
    end

    // Storage; reset overrides every write in the same cycle
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < REGS; i++) begin
            if (reset) begin
                regs_q[i] <= (i == ADDR_RP) ? DATA_W'(RP_BASE) : '0;
            end else begin
                regs_q[i] <= dado_escrita[i];
            end
        end
    end

    // Read muxes; PilhaE steers port 2 onto $rp, index 0 always reads zero
    always_comb begin
        endereco2 = PilhaE ? ADDR_W'(ADDR_RP) : addr_rt;
`ifdef REG_BYPASS_EN
        // dado_escrita already equals the stored value when nothing commits
        dado1 = reset ? regs_q[addr_rs] : dado_escrita[addr_rs];
        dado2 = reset ? regs_q[endereco2] : dado_escrita[endereco2];
`else
        dado1 = regs_q[addr_rs];
        dado2 = regs_q[endereco2];
`endif
        if (addr_rs == ADDR_W'(ADDR_ZERO)) dado1 = '0;
        if (endereco2 == ADDR_W'(ADDR_ZERO)) dado2 = '0;
    end

endmodule
